// File: rtl/shift_sequencer_if.sv
// Operand/control bus between the requester, the shift sequencer and the
// combinational single-position shifter.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] operand;
  logic [CNT_W-1:0] count;
  logic [1:0]       H;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S_Result;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, mode, operand, count, S_Result,
    input  H, B, busy, done, result
  );

  modport slave (
    input  start, mode, operand, count, S_Result,
    output H, B, busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: drives the single-position shifter once per
// clock, feeding S_Result back into the accumulator until the count runs out.
module shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d  = bus.operand;
          rem_d  = bus.count;
          mode_d = bus.mode;
          // Transfer/reserved modes and zero counts skip straight to DONE.
          if ((bus.count == '0) || (bus.mode == 2'b00) || (bus.mode == 2'b11))
            state_d = S_DONE;
          else
            state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = bus.S_Result;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1))
          state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.H      = (state_q == S_SHIFT) ? mode_q : 2'b00;
  assign bus.B      = acc_q;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = acc_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller that wraps the single-position `Shifter` stage of the function unit. It accepts an operand, a shift mode and a shift count, then drives the shifter once per clock and feeds `S_Result` back as the next operand until the count is exhausted. The final value is presented on `result` with a one-cycle `done` pulse. It sits between the operand bus / function-select decode and the combinational shifter, and it owns the shifter's `H` and `B` inputs.

## Interface
- `WIDTH`, 8: data width; matches the shifter's `B` and `S_Result` width.
- `CNT_W`, 4: shift-count width; counts from 0 to 2^CNT_W-1.

- `clk`  input  1  sole clock; everything samples on its rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `start`  input  1  request; sampled only in IDLE.
- `mode`  input  2  00 transfer, 01 logical shift right, 10 logical shift left, 11 reserved and treated as 00.
- `operand`  input  WIDTH  initial value, latched on an accepted start.
- `count`  input  CNT_W  number of 1-bit shifts, latched on an accepted start.
- `H`  output  2  drives the shifter's `H`.
- `B`  output  WIDTH  drives the shifter's `B`; equals the internal accumulator.
- `S_Result`  input  WIDTH  combinational return from the shifter.
- `busy`  output  1  high whenever the state is not IDLE.
- `done`  output  1  one-cycle completion pulse.
- `result`  output  WIDTH  final value; it is also the accumulator.

## Operation
- States:
  - IDLE: waits for `start`.
  - SHIFT: performs one shift per cycle.
  - DONE: asserts `done` for exactly one cycle.
- Registers: `state`, `acc[WIDTH]`, `rem[CNT_W]`, `mode_r[2]`.
- IDLE with `start` asserted: `acc<=operand`, `rem<=count`, `mode_r<=mode`.
  - Goes to DONE if `count==0` or `mode` is 00 or 11.
  - Otherwise goes to SHIFT.
- IDLE without `start`: holds state and all registers.
- SHIFT: `H=mode_r` and `B=acc`. Each edge does `acc<=S_Result` and `rem<=rem-1`.
  - If `rem==1`, goes to DONE; otherwise stays in SHIFT.
- DONE: `done=1` and `H=00`; the next edge goes to IDLE. `acc` is held.
- `H` is 00 in every state except SHIFT. The shifter therefore passes `B` through when idle.
- `result=acc` at all times. It is valid while `done=1` and stays stable until the next accepted start.
- `start` is ignored while in SHIFT or DONE; no queuing. A start held high through DONE is accepted on the first IDLE cycle.
- Shifts are logical and zero-filling. A `count` of WIDTH or more yields all zeros and still takes `count` cycles; there is no early exit.
- Reset:
  - Registers: `state=IDLE`, `acc=0`, `rem=0`, `mode_r=00`.
  - Outputs: `H=00`, `B=0`, `busy=0`, `done=0`, `result=0`.
  - A reset asserted mid-SHIFT or in DONE aborts the operation on that edge. No `done` pulse is produced for the aborted operation.
- If `rst` and `start` are asserted on the same edge, reset wins and the start is dropped.

## Timing
- E0 is the edge that samples an accepted `start`.
- Effective count N is `count`, or 0 when `mode` is 00/11.
- `done` is high during the cycle after edge E0+N:
  - N=0: `done` is high in the cycle right after E0.
  - N=3: edges E0+1..E0+3 shift, and `done` is high after E0+3.
- `busy` rises after E0 and falls after edge E0+N+1.
- Throughput: one operation per N+2 cycles.
- The next start can be sampled no earlier than edge E0+N+2.
- The `S_Result` path is combinational through the shifter within one cycle. There is no pipeline register between `B` and `S_Result`.

## Test plan
- Reset check: assert `rst` for 2 cycles with random inputs.
  - Required: `busy=0`, `done=0`, `H=00`, `B=0`, `result=0`.
- Left shift: `start`, `mode=10`, `operand=0x33`, `count=3`.
  - Required: `H=10` for 3 cycles, `done` high after E0+3, `result=0x98`, `busy` high for 4 cycles.
- Right shift with an ignored start: `mode=01`, `operand=0xFF`, `count=1`, then pulse `start` again while busy.
  - Required: `result=0x7F`, `done` after E0+1, the extra start ignored, and exactly one `done` pulse.
- Transfer and zero count:
  - `mode=11`, `operand=0x55`, `count=5`: `done` after E0, `result=0x55`, `H` never non-zero.
  - `mode=10`, `count=0`: same behaviour.
- Over-range count: `mode=01`, `operand=0xFF`, `count=10`.
  - Required: `done` after E0+10 and `result=0x00`.
  - Then immediately start `mode=10`, `operand=0x01`, `count=7`: `result=0x80`.
- Mid-operation reset: `mode=10`, `operand=0x01`, `count=6`, with `rst` asserted at E0+2.
  - Required: IDLE and `result=0` after that edge, and no `done` pulse.
  - A follow-up start with `operand=0x01`, `count=2` gives `result=0x04`.
